// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default oversampling ratio,
// used by the receiver, the transmitter and the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL sets the
// value both flops take during reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {2{RESET_VAL}};
        else       sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling UART receiver: recovers LSB-first frames from rx using sample_tick.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_oversampler: unsupported parameter combination");
    end

    logic rxs;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic stop_sample;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                // armed blocks a line stuck low after an error from re-triggering
                if (rxs)          armed_d = 1'b1;
                else if (armed_q) state_d = ST_START;
            end
            ST_START: begin
                if (sample_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (rxs) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rxs;
                        state_d    = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (sample_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        // a good stop bit re-arms at once so a back-to-back start is caught
                        armed_d    = rxs;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    // Registered output pulses
    always_comb begin
        stop_sample   = (state_q == ST_STOP) && sample_tick && (tick_cnt_q == TICK_LAST);
        data_valid_d  = stop_sample && rxs;
        framing_err_d = stop_sample && !rxs;
        data_out_d    = data_valid_d ? shift_q : data_out_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = data_valid_d && (par_bit_q != ((^shift_q) ^ PARITY_ODD[0]));
`endif
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench: a tick-count frame model predicts the exact cycle and
// content of every output pulse; directed cases plus randomized frames.
module tb_uart_rx_oversampler;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_tick = 1'b0;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid, framing_err, parity_err, busy;

    uart_rx_oversampler #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   tick;
        logic [DATA_BITS-1:0] data;
        bit                   ferr;
        bit                   perr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   period = 27;
    int   div_cnt = 0;
    int   tick_num = 0;
    bit   last_edge_tick = 1'b0;
    int   n_valid = 0, n_ferr = 0, n_perr = 0;
    logic [DATA_BITS-1:0] model_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick generator; tick_num indexes the tick seen at each rising edge
    always begin
        @(posedge clk);
        last_edge_tick = sample_tick;
        if (sample_tick) tick_num++;
        #1;
        if (div_cnt >= period - 1) div_cnt = 0;
        else                       div_cnt++;
        sample_tick = (div_cnt == period - 1);
    end

    // Per-cycle comparison against the frame model
    always @(negedge clk) begin
        bit   exp_now;
        exp_t e;
        if (data_valid)  n_valid++;
        if (framing_err) n_ferr++;
        if (parity_err)  n_perr++;
        if (reset) begin
            exp_q.delete();
            model_data = '0;
            chk("reset_data_out", int'(data_out), 0);
            chk("reset_valid", int'(data_valid), 0);
            chk("reset_ferr", int'(framing_err), 0);
            chk("reset_perr", int'(parity_err), 0);
            chk("reset_busy", int'(busy), 0);
        end else begin
            exp_now = 1'b0;
            e = '{tick: 0, data: '0, ferr: 1'b0, perr: 1'b0};
            if (exp_q.size() > 0 && last_edge_tick && exp_q[0].tick == tick_num) begin
                exp_now = 1'b1;
                e = exp_q.pop_front();
                if (!e.ferr) model_data = e.data;
            end
            chk("data_valid", int'(data_valid), int'(exp_now && !e.ferr));
            chk("framing_err", int'(framing_err), int'(exp_now && e.ferr));
            chk("parity_err", int'(parity_err), int'(exp_now && e.perr && !e.ferr));
            chk("data_out", int'(data_out), int'(model_data));
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #2;
    endtask

    // Must be entered just after a tick edge (i.e. right after wait_ticks)
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_bad, input bit par_bad);
        int st;
        rx = 1'b0;
        st = tick_num;
        exp_q.push_back('{tick: st + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + 1 + PAR_EN),
                          data: d, ferr: stop_bad, perr: (PAR_EN != 0) && par_bad});
        wait_ticks(OVERSAMPLE);
        chk("busy_in_frame", int'(busy), 1);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = d[i];
            wait_ticks(OVERSAMPLE);
        end
        if (PAR_EN != 0) begin
            rx = (^d) ^ PARITY_ODD[0] ^ par_bad;
            wait_ticks(OVERSAMPLE);
        end
        rx = ~stop_bad;
        wait_ticks(OVERSAMPLE);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: cycle budget exhausted, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int nv, nf;
        logic [DATA_BITS-1:0] d;
        bit sb, pb;
        reset = 1'b1;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        wait_ticks(4);

        // 1. plain frame
        nv = n_valid;
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("t1_data", int'(data_out), 'hA5);
        chk("t1_valid_count", n_valid - nv, 1);
        chk("t1_busy_idle", int'(busy), 0);

        // 2. short glitch on the line
        nv = n_valid; nf = n_ferr;
        rx = 1'b0;
        wait_ticks(2);
        chk("t2_busy_start", int'(busy), 1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(2 * OVERSAMPLE);
        chk("t2_no_valid", n_valid - nv, 0);
        chk("t2_no_ferr", n_ferr - nf, 0);
        chk("t2_busy_idle", int'(busy), 0);

        // 3. framing error, line then held low
        nv = n_valid; nf = n_ferr;
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_ticks(2 * OVERSAMPLE);
        chk("t3_busy_low_line", int'(busy), 0);
        rx = 1'b1;
        wait_ticks(4);
        chk("t3_ferr_count", n_ferr - nf, 1);
        chk("t3_no_valid", n_valid - nv, 0);
        chk("t3_data_kept", int'(data_out), 'hA5);

        // 4. back-to-back frames
        nv = n_valid;
        send_frame(8'h00, 1'b0, 1'b0);
        chk("t4_first", int'(data_out), 'h00);
        send_frame(8'hFF, 1'b0, 1'b0);
        chk("t4_second", int'(data_out), 'hFF);
        chk("t4_valid_count", n_valid - nv, 2);
        wait_ticks(4);

        // 5. reset during data bit 3, then a clean frame
        d = 8'hC3;
        rx = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_ticks(OVERSAMPLE);
        end
        rx = d[3];
        wait_ticks(OVERSAMPLE / 2);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        wait_ticks(4);
        chk("t5_data_cleared", int'(data_out), 0);
        chk("t5_busy", int'(busy), 0);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("t5_data", int'(data_out), 'h5A);

`ifdef UART_RX_PARITY_EN
        // 6. parity mismatch still delivers data
        nv = n_valid; nf = n_perr;
        send_frame(8'h01, 1'b0, 1'b1);
        chk("t6_data", int'(data_out), 'h01);
        chk("t6_valid", n_valid - nv, 1);
        chk("t6_perr", n_perr - nf, 1);
`endif

        // Randomized frames with varying tick rate and gaps
        for (int i = 0; i < 16; i++) begin
            d  = DATA_BITS'($urandom);
            sb = ($urandom_range(0, 5) == 0);
            pb = 1'($urandom_range(0, 1));
            send_frame(d, sb, pb);
            rx = 1'b1;
            if (sb || $urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                period = $urandom_range(4, 8);
                wait_ticks($urandom_range(1, 20));
            end
        end

        wait_ticks(4);
        chk("all_expected_seen", exp_q.size(), 0);
        chk("final_busy", int'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
